// File: rtl/waterfall_history_buffer_pkg.sv
// Shared parameters and constants for the waterfall history buffer.
package waterfall_pkg;

    localparam int unsigned DATA_W_DEF   = 8;
    localparam int unsigned NUM_BINS_DEF = 512;
    localparam int unsigned NUM_ROWS_DEF = 256;
    localparam int unsigned DECIM_W      = 8;

    localparam logic MODE_LAST = 1'b0;
    localparam logic MODE_MAX  = 1'b1;

    localparam int unsigned ERR_LONG  = 0;
    localparam int unsigned ERR_SHORT = 1;

    // A programmed decimation of 0 behaves as 1 frame per row.
    function automatic logic [DECIM_W-1:0] decim_eff(input logic [DECIM_W-1:0] d);
        return (d == '0) ? DECIM_W'(1) : d;
    endfunction

endpackage

// File: rtl/waterfall_history_buffer_if.sv
// Frame input stream and display read port of the waterfall history buffer.
interface waterfall_history_buffer_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned BIN_W  = 9,
    parameter int unsigned ROW_W  = 8
);
    logic [DATA_W-1:0] log_in;
    logic              log_valid;
    logic              log_last;
    logic              rd_en;
    logic [BIN_W-1:0]  rd_bin;
    logic [ROW_W-1:0]  rd_row;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    modport master (
        output log_in, log_valid, log_last, rd_en, rd_bin, rd_row,
        input  rd_data, rd_valid
    );

    modport slave (
        input  log_in, log_valid, log_last, rd_en, rd_bin, rd_row,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/waterfall_history_buffer_sdp_ram.sv
// Simple dual-port RAM: synchronous write port A, registered read port B.
module wf_sdp_ram #(
    parameter  int unsigned DEPTH = 16,
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Registered read port; holds its value while idle.
    always_ff @(posedge clk) begin
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/waterfall_history_buffer.sv
// Circular waterfall row store with decimation, peak-hold, freeze and frame checks.
module waterfall_history_buffer
    import waterfall_pkg::*;
#(
    parameter  int unsigned DATA_W   = DATA_W_DEF,
    parameter  int unsigned NUM_BINS = NUM_BINS_DEF,
    parameter  int unsigned NUM_ROWS = NUM_ROWS_DEF,
    localparam int unsigned BIN_W    = $clog2(NUM_BINS),
    localparam int unsigned ROW_W    = $clog2(NUM_ROWS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DECIM_W-1:0] cfg_decim_i,
    input  logic               cfg_mode_i,
    input  logic               freeze_i,
    input  logic               err_clr_i,
    waterfall_history_buffer_if.slave bus,
    output logic [ROW_W-1:0]   rows_filled_o,
    output logic               row_done_o,
    output logic [1:0]         frame_err_o
);

    localparam int unsigned RAM_AW  = ROW_W + BIN_W;
    localparam logic [BIN_W-1:0] BIN_MAX = BIN_W'(NUM_BINS - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(NUM_ROWS - 1);

    // Frame/group tracking
    logic [BIN_W-1:0]   bin_cnt_q, bin_cnt_d;
    logic [DECIM_W-1:0] grp_cnt_q, grp_cnt_d;
    logic [DECIM_W-1:0] decim_q, decim_d;
    logic               mode_q, mode_d;
    logic               drop_q, drop_d;
    logic               ovl_q, ovl_d;
    // S0 pipeline stage
    logic               s0_vld_q, s0_vld_d;
    logic               s0_we_q, s0_we_d;
    logic               s0_last_q, s0_last_d;
    logic [DATA_W-1:0]  s0_data_q, s0_data_d;
    logic [BIN_W-1:0]   s0_bin_q, s0_bin_d;
    logic               fwd_q, fwd_d;
    logic [DATA_W-1:0]  fwd_data_q, fwd_data_d;
    // History state and outputs
    logic [ROW_W-1:0]   head_q, head_d;
    logic [ROW_W-1:0]   rows_filled_q, rows_filled_d;
    logic               row_done_q, row_done_d;
    logic [1:0]         frame_err_q, frame_err_d;
    logic               rd_valid_q, rd_valid_d;
    logic               rd_zero_q, rd_zero_d;

    logic [ROW_W-1:0]   wr_row;
    logic [ROW_W-1:0]   phys_row;
    logic [DATA_W-1:0]  acc_rd_data;
    logic [DATA_W-1:0]  row_rd_data;
    logic [DATA_W-1:0]  acc_src;
    logic [DATA_W-1:0]  comb_val;
    logic               s1_we, s1_end, s1_commit;
    logic               first_beat, frame_drop, accept;

    assign wr_row   = head_q + ROW_W'(1);
    assign phys_row = head_q - bus.rd_row;

    // Per-bin accumulator line for peak-hold across the group.
    wf_sdp_ram #(.DEPTH(NUM_BINS), .WIDTH(DATA_W)) u_acc_ram (
        .clk       (clk),
        .wr_en_i   (s1_we),
        .wr_addr_i (s0_bin_q),
        .wr_data_i (comb_val),
        .rd_en_i   (bus.log_valid),
        .rd_addr_i (bin_cnt_q),
        .rd_data_o (acc_rd_data)
    );

    // History rows, addressed {row, bin}.
    wf_sdp_ram #(.DEPTH(NUM_ROWS * NUM_BINS), .WIDTH(DATA_W)) u_row_ram (
        .clk       (clk),
        .wr_en_i   (s1_we),
        .wr_addr_i (RAM_AW'({wr_row, s0_bin_q})),
        .wr_data_i (comb_val),
        .rd_en_i   (bus.rd_en),
        .rd_addr_i (RAM_AW'({phys_row, bus.rd_bin})),
        .rd_data_o (row_rd_data)
    );

    // Next-state: S1 combine/commit, S0 beat acceptance, errors and read bookkeeping.
    always_comb begin
        bin_cnt_d     = bin_cnt_q;
        grp_cnt_d     = grp_cnt_q;
        decim_d       = decim_q;
        mode_d        = mode_q;
        drop_d        = drop_q;
        ovl_d         = ovl_q;
        s0_vld_d      = 1'b0;
        s0_we_d       = 1'b0;
        s0_last_d     = 1'b0;
        s0_data_d     = s0_data_q;
        s0_bin_d      = s0_bin_q;
        fwd_d         = 1'b0;
        fwd_data_d    = fwd_data_q;
        head_d        = head_q;
        rows_filled_d = rows_filled_q;
        row_done_d    = 1'b0;
        frame_err_d   = frame_err_q;
        rd_valid_d    = bus.rd_en;
        rd_zero_d     = rd_zero_q;
        accept        = 1'b0;
        first_beat    = (bin_cnt_q == '0) && !ovl_q;
        frame_drop    = first_beat ? freeze_i : drop_q;

        // S1: an S1 write to the bin S0 read last cycle must bypass the stale RAM data
        acc_src = fwd_q ? fwd_data_q : acc_rd_data;
        if ((grp_cnt_q == '0) || (mode_q == MODE_LAST)) begin
            comb_val = s0_data_q;
        end else begin
            comb_val = (acc_src > s0_data_q) ? acc_src : s0_data_q;
        end
        s1_we     = s0_vld_q && s0_we_q;
        s1_end    = s0_vld_q && s0_last_q;
        s1_commit = s1_end && (grp_cnt_q == (decim_q - DECIM_W'(1)));

        if (s1_end) begin
            grp_cnt_d = s1_commit ? '0 : grp_cnt_q + DECIM_W'(1);
        end
        if (s1_commit) begin
            head_d     = wr_row;
            row_done_d = 1'b1;
            if (rows_filled_q != ROW_MAX) begin
                rows_filled_d = rows_filled_q + ROW_W'(1);
            end
        end

        if (err_clr_i) begin
            frame_err_d = '0;
        end

        // S0: grp_cnt_d reflects a commit landing this same cycle
        if (bus.log_valid) begin
            accept     = !frame_drop;
            drop_d     = frame_drop;
            s0_vld_d   = accept;
            s0_we_d    = accept && !ovl_q;
            s0_last_d  = bus.log_last;
            s0_data_d  = bus.log_in;
            s0_bin_d   = bin_cnt_q;
            fwd_d      = s1_we && (s0_bin_q == bin_cnt_q);
            fwd_data_d = comb_val;
            if (accept && first_beat && (grp_cnt_d == '0)) begin
                decim_d = decim_eff(cfg_decim_i);
                mode_d  = cfg_mode_i;
            end
            if (bus.log_last) begin
                bin_cnt_d = '0;
                ovl_d     = 1'b0;
                if (accept && !ovl_q && (bin_cnt_q != BIN_MAX)) begin
                    frame_err_d[ERR_SHORT] = 1'b1;
                end
            end else if (!ovl_q) begin
                if (bin_cnt_q == BIN_MAX) begin
                    ovl_d = 1'b1;
                    if (accept) begin
                        frame_err_d[ERR_LONG] = 1'b1;
                    end
                end else begin
                    bin_cnt_d = bin_cnt_q + BIN_W'(1);
                end
            end
        end

        if (bus.rd_en) begin
            rd_zero_d = (bus.rd_row >= rows_filled_q);
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_cnt_q     <= '0;
            grp_cnt_q     <= '0;
            decim_q       <= DECIM_W'(1);
            mode_q        <= MODE_LAST;
            drop_q        <= 1'b0;
            ovl_q         <= 1'b0;
            s0_vld_q      <= 1'b0;
            s0_we_q       <= 1'b0;
            s0_last_q     <= 1'b0;
            s0_data_q     <= '0;
            s0_bin_q      <= '0;
            fwd_q         <= 1'b0;
            fwd_data_q    <= '0;
            head_q        <= ROW_MAX;
            rows_filled_q <= '0;
            row_done_q    <= 1'b0;
            frame_err_q   <= '0;
            rd_valid_q    <= 1'b0;
            rd_zero_q     <= 1'b1;
        end else begin
            bin_cnt_q     <= bin_cnt_d;
            grp_cnt_q     <= grp_cnt_d;
            decim_q       <= decim_d;
            mode_q        <= mode_d;
            drop_q        <= drop_d;
            ovl_q         <= ovl_d;
            s0_vld_q      <= s0_vld_d;
            s0_we_q       <= s0_we_d;
            s0_last_q     <= s0_last_d;
            s0_data_q     <= s0_data_d;
            s0_bin_q      <= s0_bin_d;
            fwd_q         <= fwd_d;
            fwd_data_q    <= fwd_data_d;
            head_q        <= head_d;
            rows_filled_q <= rows_filled_d;
            row_done_q    <= row_done_d;
            frame_err_q   <= frame_err_d;
            rd_valid_q    <= rd_valid_d;
            rd_zero_q     <= rd_zero_d;
        end
    end

    assign rows_filled_o = rows_filled_q;
    assign row_done_o    = row_done_q;
    assign frame_err_o   = frame_err_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_zero_q ? '0 : row_rd_data;

endmodule
